// File: rtl/mincore_issue_ctl.sv
// mincore_issue_ctl -- in-order single-issue controller for the minimal test core.
//
// Sits between the small-instruction decoder and the regfile/ALU/shifter/jump
// datapath.  An instruction issues at cycle t when in_valid & in_ready.  It is
// in the RD stage at t+1, and it writes back at t+2 (ALU class) or t+3 (shift
// class).
//
// Hazards that hold off issue:
//   - register RAW and WAW, tracked by a per-register busy scoreboard;
//   - a jump issuing while flag setters are still in flight;
//   - write-port collision: an ALU op directly after a shift.
//
// A resolved mispredict kills the instruction issued right after the jump.
// Halt drains the pending writebacks and then parks the core.
//
// Optional feature macro: MINCORE_BYPASS_EN.  When it is defined, ALU results
// are forwarded one cycle early and the fwd_a/fwd_b ports exist.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   in_*                     decoded instruction and its handshake
//   jmp_done, jmp_mispred    jump resolution, exactly at the jump's t+2
//   issue_*                  RD-stage valid and class
//   wb_wen, wb_addr          regfile write port
//   except                   one-cycle redirect pulse
//   stall                    in_valid & ~in_ready
//   halted                   core parked
//   fwd_a, fwd_b             operand bypass selects (bypass build only)
module mincore_issue_ctl #(
  parameter int REG_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [REG_WIDTH-1:0] in_rA,
  input  logic [REG_WIDTH-1:0] in_rB,
  input  logic [REG_WIDTH-1:0] in_rC,
  input  logic                 in_rA_use,
  input  logic                 in_rB_use,
  input  logic                 in_rC_use,
  input  logic [REG_WIDTH-1:0] in_rT,
  input  logic                 in_rT_use,
  input  logic                 in_isShift,
  input  logic                 in_isJump,
  input  logic                 in_setsFlags,
  input  logic                 in_halt,
  input  logic                 jmp_done,
  input  logic                 jmp_mispred,
  output logic                 issue_valid,
  output logic                 issue_isShift,
  output logic                 issue_isJump,
  output logic                 wb_wen,
  output logic [REG_WIDTH-1:0] wb_addr,
  output logic                 except,
  output logic                 stall,
`ifdef MINCORE_BYPASS_EN
  output logic                 fwd_a,
  output logic                 fwd_b,
`endif
  output logic                 halted
);

  localparam int NREG = 1 << REG_WIDTH;

  typedef enum logic [1:0] {RUN, FLUSH, DRAIN, HALTED} state_t;

  state_t stateReg, stateNext;

  logic [NREG-1:0]      busyReg;
  logic [NREG-1:0]      busyNext;
  logic [2:0]           flagCntReg;
  logic                 issueIsHalt;

  // Reservation shift register.  Slot 0 is the instruction writing back this
  // cycle.  ALU ops enter slot 1 and shifts enter slot 2, so each one reaches
  // slot 0 at its own writeback cycle.  Entries that do not write still travel
  // down the register, so that their flag count is released at writeback.
  logic [2:0]           resvValid, resvWen, resvShift, resvFlags;
  logic [REG_WIDTH-1:0] resvAddr [3];

  logic mispred, fire, killAlu, killShift, pendingWb;
  logic srcBusy, wawBusy, flagBlock, portBlock;
  logic incFlag, decFlag, decKill;

  assign mispred = jmp_done & jmp_mispred;

  // The instruction in RD when the jump resolves is the younger one to kill.
  // Its class tells which reservation slot it occupies.
  assign killAlu   = mispred & issue_valid & ~issue_isShift;
  assign killShift = mispred & issue_valid & issue_isShift;

  assign srcBusy = (in_rA_use & busyReg[in_rA]) |
                   (in_rB_use & busyReg[in_rB]) |
                   (in_rC_use & busyReg[in_rC]);
  assign wawBusy   = in_rT_use & busyReg[in_rT];
  assign flagBlock = in_isJump & (flagCntReg != 3'd0);
  // A shift issued last cycle sits in slot 2.  An ALU op issued now would
  // land in slot 1 next cycle, at the same time as that shift.
  assign portBlock = ~in_isShift & resvValid[2];

  // Gating with rst keeps every output at zero while reset is held.
  assign in_ready = ~rst & (stateReg == RUN) & ~srcBusy & ~wawBusy &
                    ~flagBlock & ~portBlock & ~mispred;
  assign stall    = ~rst & in_valid & ~in_ready;
  assign fire     = in_valid & in_ready;

  assign wb_wen  = resvValid[0] & resvWen[0];
  assign wb_addr = resvAddr[0];
  assign halted  = (stateReg == HALTED);

  // Slot 0 writes back this cycle, so only the later slots count as pending.
  assign pendingWb = |(resvValid[2:1] & resvWen[2:1]);

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      RUN:    if (mispred)              stateNext = FLUSH;
              else if (fire & in_halt)  stateNext = DRAIN;
      FLUSH:  stateNext = RUN;
      // A mispredict wins over the drain only when it kills the halt itself.
      DRAIN:  if (mispred & issue_valid & issueIsHalt) stateNext = FLUSH;
              else if (!pendingWb)                     stateNext = HALTED;
      HALTED: stateNext = HALTED;
      default: stateNext = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stateReg <= RUN;
    else     stateReg <= stateNext;
  end

  // Scoreboard.  A clear and a set on the same register in one cycle leave the
  // bit set, because the issue-time set is applied last.
  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_busy
      logic clr;
      always_comb begin
        clr = (wb_wen & (wb_addr == REG_WIDTH'(gi))) |
              (killAlu & resvValid[1] & resvWen[1] & (resvAddr[1] == REG_WIDTH'(gi))) |
              (killShift & resvValid[2] & resvWen[2] & (resvAddr[2] == REG_WIDTH'(gi)));
`ifdef MINCORE_BYPASS_EN
        // An ALU result can be forwarded from t+2, so its busy bit is
        // released while the producer is in RD.
        clr = clr | (resvValid[1] & resvWen[1] & ~resvShift[1] &
                     (resvAddr[1] == REG_WIDTH'(gi)));
`endif
        busyNext[gi] = (fire & in_rT_use & (in_rT == REG_WIDTH'(gi))) |
                       (busyReg[gi] & ~clr);
      end
      always_ff @(posedge clk or posedge rst) begin
        if (rst) busyReg[gi] <= 1'b0;
        else     busyReg[gi] <= busyNext[gi];
      end
    end
  endgenerate

  assign incFlag = fire & in_setsFlags;
  assign decFlag = resvValid[0] & resvFlags[0];
  assign decKill = (killAlu & resvValid[1] & resvFlags[1]) |
                   (killShift & resvValid[2] & resvFlags[2]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flagCntReg    <= 3'd0;
      resvValid     <= 3'b000;
      resvWen       <= 3'b000;
      resvShift     <= 3'b000;
      resvFlags     <= 3'b000;
      resvAddr[0]   <= '0;
      resvAddr[1]   <= '0;
      resvAddr[2]   <= '0;
      issue_valid   <= 1'b0;
      issue_isShift <= 1'b0;
      issue_isJump  <= 1'b0;
      issueIsHalt   <= 1'b0;
      except        <= 1'b0;
    end else begin
      flagCntReg <= flagCntReg + {2'b00, incFlag} - {2'b00, decFlag} - {2'b00, decKill};

      resvValid[0] <= resvValid[1] & ~killAlu;
      resvWen[0]   <= resvWen[1];
      resvShift[0] <= resvShift[1];
      resvFlags[0] <= resvFlags[1];
      resvAddr[0]  <= resvAddr[1];

      if (fire & ~in_isShift) begin
        resvValid[1] <= 1'b1;
        resvWen[1]   <= in_rT_use;
        resvShift[1] <= 1'b0;
        resvFlags[1] <= in_setsFlags;
        resvAddr[1]  <= in_rT;
      end else begin
        resvValid[1] <= resvValid[2] & ~killShift;
        resvWen[1]   <= resvWen[2];
        resvShift[1] <= resvShift[2];
        resvFlags[1] <= resvFlags[2];
        resvAddr[1]  <= resvAddr[2];
      end

      resvValid[2] <= fire & in_isShift;
      resvWen[2]   <= in_rT_use;
      resvShift[2] <= 1'b1;
      resvFlags[2] <= in_setsFlags;
      resvAddr[2]  <= in_rT;

      issue_valid   <= fire;
      issue_isShift <= fire & in_isShift;
      issue_isJump  <= fire & in_isJump;
      issueIsHalt   <= fire & in_halt;
      except        <= mispred;
    end
  end

`ifdef MINCORE_BYPASS_EN
  // Select the forwarded operand when the consumer issues in the same cycle
  // as its ALU producer's writeback.  Shift results are never forwarded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_a <= 1'b0;
      fwd_b <= 1'b0;
    end else begin
      fwd_a <= fire & in_rA_use & wb_wen & ~resvShift[0] & (in_rA == wb_addr);
      fwd_b <= fire & in_rB_use & wb_wen & ~resvShift[0] & (in_rB == wb_addr);
    end
  end
`endif

endmodule
